// File: rtl/retospect_tickgen.sv
// rtl/retospect_tickgen.sv - multi-channel decay-tick generator loaded through a serial config chain
// Optional per-channel sync phase offset: define TICKGEN_PHASE_EN.
module retospect_tickgen #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              config_en,
    input  logic              bs_in,
    output logic              bs_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH+1:0] clockbus
);
`ifdef TICKGEN_PHASE_EN
    localparam int CFG_W = 2 * CNT_W + 2;
`else
    localparam int CFG_W = CNT_W + 2;
`endif
    localparam int CHAIN_W = NUM_CH * CFG_W;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_TOGGLE   = 2'b11
    } mode_e;

    logic [CHAIN_W-1:0] chain_q, chain_d;

    // ch0 occupies the top of the chain, so a right shift feeds bs_in into ch0's MSB.
    always_comb begin
        chain_d = chain_q;
        if (config_en && !sync) begin
            chain_d = {bs_in, chain_q[CHAIN_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign bs_out = chain_q[0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CFG_W-1:0] word;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] sync_load;
        logic [CNT_W-1:0] count_q, count_d;
        mode_e            mode;
        logic             wrap;
        logic             tick_q, tick_d;
        logic             done_q, done_d;

        assign word   = chain_q[(NUM_CH-1-g)*CFG_W +: CFG_W];
        assign period = word[CNT_W-1:0];
        assign mode   = mode_e'(word[CNT_W +: 2]);
        assign wrap   = (count_q == period);

`ifdef TICKGEN_PHASE_EN
        logic [CNT_W-1:0] phase;
        assign phase     = word[CNT_W+2 +: CNT_W];
        assign sync_load = (phase > period) ? '0 : phase;
`else
        assign sync_load = '0;
`endif

        always_comb begin
            count_d = count_q;
            tick_d  = tick_q;
            done_d  = done_q;
            if (sync) begin
                count_d = sync_load;
                tick_d  = 1'b0;
                done_d  = 1'b0;
            end else if (config_en) begin
                tick_d = 1'b0;
            end else begin
                case (mode)
                    MODE_OFF: begin
                        count_d = '0;
                        tick_d  = 1'b0;
                    end
                    MODE_PERIODIC: begin
                        count_d = wrap ? '0 : count_q + 1'b1;
                        tick_d  = wrap;
                    end
                    MODE_ONESHOT: begin
                        if (done_q) begin
                            count_d = '0;
                            tick_d  = 1'b0;
                        end else begin
                            count_d = wrap ? '0 : count_q + 1'b1;
                            tick_d  = wrap;
                            done_d  = wrap;
                        end
                    end
                    MODE_TOGGLE: begin
                        count_d = wrap ? '0 : count_q + 1'b1;
                        if (wrap) begin
                            tick_d = ~tick_q;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= '0;
                tick_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                tick_q  <= tick_d;
                done_q  <= done_d;
            end
        end

        assign tick[g] = tick_q;
    end

    assign clockbus = {tick, 2'b10};

endmodule

// File: tb/tb_retospect_tickgen.sv
// tb/tb_retospect_tickgen.sv - self-checking bench for retospect_tickgen
module tb_retospect_tickgen;
    localparam int NUM_CH  = 6;
    localparam int CNT_W   = 8;
    localparam int CFG_W   = CNT_W + 2;
    localparam int CHAIN_W = NUM_CH * CFG_W;

    logic              clk = 1'b0;
    logic              reset, sync, config_en, bs_in, bs_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH+1:0] clockbus;

    int tests = 0;
    int fails = 0;

    logic [1:0]       cfg_mode [NUM_CH];
    logic [CNT_W-1:0] cfg_per  [NUM_CH];
    logic             stream_q [$];

    typedef struct {
        int               ch;
        logic [1:0]       mode;
        logic [CNT_W-1:0] per;
        logic [15:0]      pat;   // bit k = expected tick after run edge k+1
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    retospect_tickgen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sync     (sync),
        .config_en(config_en),
        .bs_in    (bs_in),
        .bs_out   (bs_out),
        .tick     (tick),
        .clockbus (clockbus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        config_en = 1'b1;
        bs_in     = b;
        step();
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_mode[c] = 2'b00;
            cfg_per[c]  = '0;
        end
    endtask

    // Last channel's word goes in first, LSB first.
    task automatic load_cfg();
        logic [CFG_W-1:0] w;
        stream_q.delete();
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            w = {cfg_mode[c], cfg_per[c]};
            for (int b = 0; b < CFG_W; b++) begin
                stream_q.push_back(w[b]);
                shift_bit(w[b]);
            end
        end
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    function automatic logic ref_tick(input logic [1:0] mode, input int p, input int n);
        int len;
        len = p + 1;
        case (mode)
            2'b01:   return (n > 0) && (n % len == 0);
            2'b10:   return n == len;
            2'b11:   return ((n / len) % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic [NUM_CH-1:0] one_hot;
        logic [NUM_CH-1:0] exp_tick;
        logic              b;
        logic              s;
        int                n [NUM_CH];
        int                cnt, first;

        vecs[0] = '{0, 2'b01, 8'd3, 16'h8888};
        vecs[1] = '{1, 2'b10, 8'd2, 16'h0004};
        vecs[2] = '{2, 2'b11, 8'd1, 16'h6666};
        vecs[3] = '{3, 2'b01, 8'd0, 16'hFFFF};
        vecs[4] = '{4, 2'b00, 8'd5, 16'h0000};
        vecs[5] = '{5, 2'b11, 8'd0, 16'h5555};
        vecs[6] = '{0, 2'b10, 8'd0, 16'h0001};

        reset = 1'b1; sync = 1'b0; config_en = 1'b0; bs_in = 1'b0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("reset_tick", tick, '0);
        check("reset_clockbus", clockbus, {{NUM_CH{1'b0}}, 2'b10});
        check("reset_bs_out", bs_out, 1'b0);

        // Chain replay: second pass of shifting returns the first pass in order.
        stream_q.delete();
        for (int k = 0; k < CHAIN_W; k++) begin
            b = 1'($urandom_range(0, 1));
            stream_q.push_back(b);
            shift_bit(b);
        end
        for (int k = 0; k < CHAIN_W; k++) begin
            check($sformatf("replay_bit%0d", k), bs_out, stream_q[k]);
            shift_bit(1'($urandom_range(0, 1)));
        end

        // Table vectors: one active channel, sync, then 16 run edges.
        for (int i = 0; i < 7; i++) begin
            clear_cfg();
            cfg_mode[vecs[i].ch] = vecs[i].mode;
            cfg_per[vecs[i].ch]  = vecs[i].per;
            load_cfg();
            do_sync();
            one_hot = NUM_CH'(1) << vecs[i].ch;
            for (int k = 0; k < 16; k++) begin
                step();
                check($sformatf("vec%0d_edge%0d", i, k + 1), tick, vecs[i].pat[k] ? one_hot : '0);
            end
        end

        // One-shot re-arms on each sync.
        clear_cfg();
        cfg_mode[1] = 2'b10; cfg_per[1] = 8'd2;
        load_cfg();
        for (int r = 0; r < 2; r++) begin
            do_sync();
            cnt = 0; first = -1;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (tick[1]) begin
                    cnt++;
                    if (first < 0) first = k;
                end
            end
            check($sformatf("oneshot_count_r%0d", r), cnt, 1);
            check($sformatf("oneshot_edge_r%0d", r), first, 3);
        end

        // Toggle frozen by a full recirculating config pass.
        clear_cfg();
        cfg_mode[2] = 2'b11; cfg_per[2] = 8'd1;
        load_cfg();
        do_sync();
        step(); step(); step();
        check("toggle_pre_freeze", tick, 6'b000100);
        for (int k = 0; k < CHAIN_W; k++) begin
            config_en = 1'b1;
            bs_in     = bs_out;
            step();
            check($sformatf("toggle_frozen%0d", k), tick, '0);
        end
        config_en = 1'b0; bs_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("toggle_resume%0d", k), tick[2], (k == 2 || k == 3) ? 1'b0 : 1'b1);
        end

        // Largest period.
        clear_cfg();
        cfg_mode[0] = 2'b01; cfg_per[0] = 8'd255;
        load_cfg();
        do_sync();
        cnt = 0;
        for (int k = 0; k < 255; k++) begin
            step();
            if (tick[0]) cnt++;
        end
        check("pmax_no_early_tick", cnt, 0);
        step();
        check("pmax_tick_edge256", tick[0], 1'b1);
        step();
        check("pmax_after", tick[0], 1'b0);

        // sync and config_en together: counters clear, chain does not shift.
        clear_cfg();
        cfg_mode[0] = 2'b01; cfg_per[0] = 8'd5;
        load_cfg();
        do_sync();
        step(); step(); step();
        sync = 1'b1; config_en = 1'b1; bs_in = 1'b1;
        step();
        sync = 1'b0; config_en = 1'b0; bs_in = 1'b0;
        check("sync_cfg_tick", tick, '0);
        for (int k = 0; k < 5; k++) step();
        check("sync_cfg_edge5", tick[0], 1'b0);
        step();
        check("sync_cfg_edge6", tick[0], 1'b1);
        for (int k = 0; k < CHAIN_W; k++) begin
            check($sformatf("sync_cfg_chain%0d", k), bs_out, stream_q[k]);
            shift_bit(bs_out);
        end

        // Reset mid-shift discards the partial load.
        for (int k = 0; k < 30; k++) shift_bit(1'b1);
        reset = 1'b1; config_en = 1'b1; bs_in = 1'b1;
        step();
        reset = 1'b0; config_en = 1'b0; bs_in = 1'b0;
        for (int k = 0; k < CHAIN_W; k++) begin
            check($sformatf("reset_chain%0d", k), bs_out, 1'b0);
            shift_bit(1'b0);
        end

        // Randomised runs against the elapsed-edge reference model.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cfg_mode[c] = 2'($urandom_range(0, 3));
                cfg_per[c]  = CNT_W'($urandom_range(0, 6));
            end
            load_cfg();
            do_sync();
            for (int c = 0; c < NUM_CH; c++) n[c] = 0;
            for (int cyc = 0; cyc < 120; cyc++) begin
                s = ($urandom_range(0, 19) == 0);
                sync = s;
                step();
                sync = 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    n[c]        = s ? 0 : n[c] + 1;
                    exp_tick[c] = ref_tick(cfg_mode[c], int'(cfg_per[c]), n[c]);
                end
                check($sformatf("rand_r%0d_c%0d", r, cyc), clockbus, {exp_tick, 2'b10});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
